pipe_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It merges the decode-stage hazard stall request with a counted multi-cycle execute-stage stall (multiply-accumulate, iterative divide). It drives the per-stage stall vector consumed by the pc, if/id, id/ex, ex/mem and mem/wb pipeline registers. It also owns flush sequencing and a saturating stall-cycle statistics counter.

---
 rtl/pipe_stall_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges decode hazard stalls with counted
// multi-cycle execute stalls, sequences flushes and counts stalled cycles.
module pipe_stall_ctrl #(
  parameter int unsigned CYC_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_start,
  input  logic [CYC_W-1:0] ex_cycles,
  input  logic             flush_req,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             ex_busy_o,
  output logic             ex_done_o,
  output logic [CYC_W-1:0] ex_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  state_t           r_state;
  logic [CYC_W-1:0] r_ex_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_ex_go;
  logic w_ex_stall;

  always_comb begin
    w_ex_go    = (r_state == S_IDLE) && ex_start && (ex_cycles != '0);
    w_ex_stall = (r_state == S_BUSY) || w_ex_go;
    stall_o    = '0;
    flush_o    = 1'b0;
    ex_busy_o  = 1'b0;
    ex_done_o  = 1'b0;
    if (rst) begin
      stall_o = '0;
    end else if (flush_req) begin
      flush_o = 1'b1;
    end else begin
      ex_busy_o = w_ex_stall;
      ex_done_o = (r_state == S_DONE);
      // EX stall is a superset of ID stall, so a pending hazard is simply masked.
      if (w_ex_stall)
        stall_o = STALL_EX;
      else if (stallreq_id)
        stall_o = STALL_ID;
    end
  end

  // Registered values are also forced to zero while reset is held.
  assign ex_cnt_o    = rst ? '0 : r_ex_cnt;
  assign stall_cnt_o = rst ? '0 : r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ex_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if ((stall_o != '0) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      if (flush_req) begin
        r_state  <= S_IDLE;
        r_ex_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_ex_go) begin
              r_ex_cnt <= ex_cycles - 1'b1;
              r_state  <= (ex_cycles == CYC_W'(1)) ? S_DONE : S_BUSY;
            end
          end
          S_BUSY: begin
            if (r_ex_cnt == CYC_W'(1)) begin
              r_ex_cnt <= '0;
              r_state  <= S_DONE;
            end else begin
              r_ex_cnt <= r_ex_cnt - 1'b1;
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: begin
            r_state  <= S_IDLE;
            r_ex_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a behavioural model pushes expected
// outputs per cycle; each scenario task pops and compares them.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst, stallreq_id, ex_start, flush_req;
  logic [5:0] ex_cycles;

  logic [5:0]  stall_o, sat_stall;
  logic        flush_o, ex_busy_o, ex_done_o;
  logic        sat_flush, sat_busy, sat_done;
  logic [5:0]  ex_cnt_o, sat_cnt;
  logic [31:0] stall_cnt_o;
  logic [1:0]  sat_scnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CYC_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
    .ex_cycles(ex_cycles), .flush_req(flush_req), .stall_o(stall_o),
    .flush_o(flush_o), .ex_busy_o(ex_busy_o), .ex_done_o(ex_done_o),
    .ex_cnt_o(ex_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  // Narrow counter copy so saturation is reachable in a few cycles.
  pipe_stall_ctrl #(.CYC_W(6), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
    .ex_cycles(ex_cycles), .flush_req(flush_req), .stall_o(sat_stall),
    .flush_o(sat_flush), .ex_busy_o(sat_busy), .ex_done_o(sat_done),
    .ex_cnt_o(sat_cnt), .stall_cnt_o(sat_scnt)
  );

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic        busy;
    logic        done;
    logic [5:0]  cnt;
    logic [31:0] scnt;
    logic [1:0]  sat;
  } out_t;

  typedef struct packed {
    logic       r;
    logic       sid;
    logic       st;
    logic [5:0] cyc;
    logic       fl;
  } stim_t;

  out_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: 0 idle, 1 busy, 2 done
  int          m_st   = 0;
  logic [5:0]  m_cnt  = '0;
  logic [31:0] m_scnt = '0;
  logic [1:0]  m_sat  = '0;
  logic [5:0]  m_stall;
  stim_t       cur;

  function automatic stim_t mk(input logic r, sid, st, input logic [5:0] cyc, input logic fl);
    stim_t s;
    s.r = r; s.sid = sid; s.st = st; s.cyc = cyc; s.fl = fl;
    return s;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.stall = stall_o; o.flush = flush_o; o.busy = ex_busy_o; o.done = ex_done_o;
    o.cnt = ex_cnt_o; o.scnt = stall_cnt_o; o.sat = sat_scnt;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    out_t e;
    logic ex_cond;
    cur = s;
    rst = s.r; stallreq_id = s.sid; ex_start = s.st; ex_cycles = s.cyc; flush_req = s.fl;
    ex_cond = (m_st == 1) || (m_st == 0 && s.st && s.cyc != 0);
    e = '0;
    if (!s.r) begin
      e.cnt = m_cnt; e.scnt = m_scnt; e.sat = m_sat;
      if (s.fl) e.flush = 1'b1;
      else begin
        e.busy  = ex_cond;
        e.done  = (m_st == 2);
        e.stall = ex_cond ? 6'b001111 : (s.sid ? 6'b000111 : 6'b000000);
      end
    end
    m_stall = e.stall;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur.r) begin
      m_st = 0; m_cnt = '0; m_scnt = '0; m_sat = '0;
    end else begin
      if (m_stall != 0) begin
        if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        if (m_sat != 2'd3) m_sat = m_sat + 1;
      end
      if (cur.fl) begin
        m_st = 0; m_cnt = '0;
      end else if (m_st == 0) begin
        if (cur.st && cur.cyc != 0) begin
          m_cnt = cur.cyc - 1;
          m_st  = (cur.cyc == 1) ? 2 : 1;
        end
      end else if (m_st == 1) begin
        if (m_cnt == 1) begin m_cnt = 0; m_st = 2; end
        else m_cnt = m_cnt - 1;
      end else begin
        m_st = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t q[$];
    out_t g, e;
    q.push_back(mk(1, 1, 1, 6'd4, 0));
    q.push_back(mk(1, 0, 0, 6'd0, 1));
    repeat (10) q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset step%0d: got stall=%b fl=%b busy=%b done=%b cnt=%0d scnt=%0d sat=%0d want stall=%b fl=%b busy=%b done=%b cnt=%0d scnt=%0d sat=%0d",
                 i, g.stall, g.flush, g.busy, g.done, g.cnt, g.scnt, g.sat, e.stall, e.flush, e.busy, e.done, e.cnt, e.scnt, e.sat);
      end
      tick();
    end
  endtask

  task automatic test_id_stall();
    stim_t q[$];
    out_t g, e;
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    q.push_back(mk(0, 1, 0, 6'd0, 0));
    q.push_back(mk(0, 1, 0, 6'd0, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL id_stall step%0d: got stall=%b fl=%b busy=%b done=%b cnt=%0d scnt=%0d want stall=%b fl=%b busy=%b done=%b cnt=%0d scnt=%0d",
                 i, g.stall, g.flush, g.busy, g.done, g.cnt, g.scnt, e.stall, e.flush, e.busy, e.done, e.cnt, e.scnt);
      end
      tick();
    end
    #1; total++;
    if (stall_cnt_o !== 32'd2) begin
      bad++;
      $display("FAIL id_stall_count: got %0d want 2", stall_cnt_o);
    end
  endtask

  task automatic test_ex3();
    stim_t q[$];
    out_t g, e;
    logic [5:0] post[$];
    // ex_cycles wanders while busy; it must be ignored
    q.push_back(mk(0, 0, 1, 6'd3, 0));
    q.push_back(mk(0, 0, 1, 6'd9, 0));
    q.push_back(mk(0, 0, 1, 6'd0, 0));
    q.push_back(mk(0, 0, 1, 6'd3, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL ex3 step%0d: got stall=%b busy=%b done=%b cnt=%0d scnt=%0d want stall=%b busy=%b done=%b cnt=%0d scnt=%0d",
                 i, g.stall, g.busy, g.done, g.cnt, g.scnt, e.stall, e.busy, e.done, e.cnt, e.scnt);
      end
      tick();
      if (i < 3) post.push_back(ex_cnt_o);
    end
    total++;
    if (post[0] !== 6'd2 || post[1] !== 6'd1 || post[2] !== 6'd0) begin
      bad++;
      $display("FAIL ex3_cnt_seq: got %0d,%0d,%0d want 2,1,0", post[0], post[1], post[2]);
    end
  endtask

  task automatic test_ex1_ex0();
    stim_t q[$];
    out_t g, e;
    q.push_back(mk(0, 0, 1, 6'd1, 0));
    q.push_back(mk(0, 0, 1, 6'd1, 0));
    q.push_back(mk(0, 0, 1, 6'd0, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL ex1_ex0 step%0d: got stall=%b busy=%b done=%b cnt=%0d want stall=%b busy=%b done=%b cnt=%0d",
                 i, g.stall, g.busy, g.done, g.cnt, e.stall, e.busy, e.done, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    stim_t q[$];
    out_t g, e;
    q.push_back(mk(0, 0, 1, 6'd5, 0));
    q.push_back(mk(0, 0, 1, 6'd5, 0));
    q.push_back(mk(0, 0, 1, 6'd5, 1));
    repeat (6) q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL flush step%0d: got stall=%b fl=%b busy=%b done=%b cnt=%0d want stall=%b fl=%b busy=%b done=%b cnt=%0d",
                 i, g.stall, g.flush, g.busy, g.done, g.cnt, e.stall, e.flush, e.busy, e.done, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_id_during_ex();
    stim_t q[$];
    out_t g, e;
    q.push_back(mk(0, 1, 1, 6'd2, 0));
    q.push_back(mk(0, 1, 1, 6'd2, 0));
    q.push_back(mk(0, 1, 1, 6'd2, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL id_during_ex step%0d: got stall=%b busy=%b done=%b cnt=%0d want stall=%b busy=%b done=%b cnt=%0d",
                 i, g.stall, g.busy, g.done, g.cnt, e.stall, e.busy, e.done, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    out_t g, e;
    repeat (3) q.push_back(mk(0, 0, 1, 6'd2, 0));
    repeat (4) q.push_back(mk(0, 0, 1, 6'd3, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL back_to_back step%0d: got stall=%b busy=%b done=%b cnt=%0d want stall=%b busy=%b done=%b cnt=%0d",
                 i, g.stall, g.busy, g.done, g.cnt, e.stall, e.busy, e.done, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    stim_t q[$];
    out_t g, e;
    q.push_back(mk(0, 0, 1, 6'd6, 0));
    q.push_back(mk(0, 0, 1, 6'd6, 0));
    q.push_back(mk(1, 0, 1, 6'd6, 0));
    repeat (7) q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset_mid step%0d: got stall=%b busy=%b done=%b cnt=%0d scnt=%0d want stall=%b busy=%b done=%b cnt=%0d scnt=%0d",
                 i, g.stall, g.busy, g.done, g.cnt, g.scnt, e.stall, e.busy, e.done, e.cnt, e.scnt);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    stim_t q[$];
    out_t g, e;
    q.push_back(mk(1, 0, 0, 6'd0, 0));
    repeat (5) q.push_back(mk(0, 1, 0, 6'd0, 0));
    q.push_back(mk(0, 0, 0, 6'd0, 1));
    q.push_back(mk(0, 0, 0, 6'd0, 0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      g = observe(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL saturation step%0d: got stall=%b scnt=%0d sat=%0d want stall=%b scnt=%0d sat=%0d",
                 i, g.stall, g.scnt, g.sat, e.stall, e.scnt, e.sat);
      end
      tick();
    end
    #1; total++;
    if (sat_scnt !== 2'b11 || stall_cnt_o !== 32'd5) begin
      bad++;
      $display("FAIL saturation_final: got sat=%0d scnt=%0d want sat=3 scnt=5", sat_scnt, stall_cnt_o);
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b0; ex_cycles = '0; flush_req = 1'b0;
    test_reset();
    test_id_stall();
    test_ex3();
    test_ex1_ex0();
    test_flush();
    test_id_during_ex();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
